stft_frame_sched: RTL

STFT_FRAME_SCHED -- requirements
Module: stft_frame_sched

---
 rtl/stft_pkg.sv | 22 ++
 rtl/stft_frame_sched_if.sv | 15 +
 rtl/stft_frame_sched_counter.sv | 36 +++
 rtl/stft_frame_sched.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/stft_pkg.sv
// Shared types and defaults for the STFT frame scheduler.
package stft_pkg;

  localparam int unsigned DEF_FFT_SIZE = 256;
  localparam int unsigned DEF_HOP_SIZE = 128;
  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned OVR_CNT_W    = 16;

  typedef logic [DEF_DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_STREAM = 2'd2
  } stft_sched_state_e;

  // Bits needed for a counter that must reach max_val (never less than one).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val > 0) ? 32'($clog2(max_val + 1)) : 32'd1;
  endfunction

endpackage

// File: rtl/stft_frame_sched_if.sv
// FFT-side sample stream bundle: valid/ready handshake plus window index and frame markers.
interface stft_frame_sched_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IDX_W  = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [IDX_W-1:0]  idx;
  logic              first;
  logic              last;

  modport master (output valid, data, idx, first, last, input ready);
  modport slave  (input valid, data, idx, first, last, output ready);
endinterface

// File: rtl/stft_frame_sched_counter.sv
// Wrapping up/down counter over 0..max_val_p with synchronous clear.
module stft_frame_sched_counter
  import stft_pkg::*;
#(
  parameter int unsigned max_val_p = 1,
  localparam int unsigned CW = cnt_w(max_val_p)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          up_i,
  input  logic          down_i,
  output logic [CW-1:0] count_o
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (up_i && !down_i) begin
      count_d = (count_q == CW'(max_val_p)) ? '0 : count_q + CW'(1);
    end else if (down_i && !up_i) begin
      count_d = (count_q == '0) ? CW'(max_val_p) : count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/stft_frame_sched.sv
// STFT frame scheduler: writes samples to an external ring RAM and streams overlapping frames.
// Optional overrun counter output enabled by STFT_SCHED_OVR_CNT_EN.
module stft_frame_sched
  import stft_pkg::*;
#(
  parameter int unsigned FFT_SIZE = DEF_FFT_SIZE,
  parameter int unsigned HOP_SIZE = DEF_HOP_SIZE,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  localparam int unsigned MEM_DEPTH = 2 * FFT_SIZE,
  localparam int unsigned AW        = $clog2(MEM_DEPTH),
  localparam int unsigned IW        = $clog2(FFT_SIZE)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              sample_valid_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic              mem_we_o,
  output logic [AW-1:0]     mem_waddr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_re_o,
  output logic [AW-1:0]     mem_raddr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [IW-1:0]     out_idx_o,
  output logic              out_first_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              overrun_o
`ifdef STFT_SCHED_OVR_CNT_EN
  ,
  output logic [OVR_CNT_W-1:0] overrun_cnt_o
`endif
);

  localparam int unsigned HW = cnt_w(HOP_SIZE - 1);

  stft_sched_state_e state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IW-1:0] smp_cnt_q, smp_cnt_d;
  logic [AW-1:0] base_q, base_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] pend_base_q, pend_base_d;
  logic          out_valid_q, out_valid_d;
  logic [IW-1:0] out_idx_q, out_idx_d;
  logic          overrun_q, overrun_d;

  logic [HW-1:0] hop_cnt;
  logic [IW-1:0] rd_cnt;
  logic          trig;
  logic          rd_en;
  logic          last_rd;
  logic [AW-1:0] trig_base;

  stft_frame_sched_counter #(.max_val_p(HOP_SIZE - 1)) u_hop_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .up_i    (sample_valid_i && (state_q != ST_FILL)),
    .down_i  (1'b0),
    .count_o (hop_cnt)
  );

  // Read index wraps to 0 on the last read, which is exactly the start of any follow-on frame.
  stft_frame_sched_counter #(.max_val_p(FFT_SIZE - 1)) u_rd_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .up_i    (rd_en),
    .down_i  (1'b0),
    .count_o (rd_cnt)
  );

  // Trigger detection: priming count in FILL, hop cadence afterwards.
  always_comb begin
    trig      = 1'b0;
    trig_base = AW'(wr_ptr_q + AW'(1) - AW'(FFT_SIZE));
    if (sample_valid_i) begin
      trig = (state_q == ST_FILL) ? (smp_cnt_q == IW'(FFT_SIZE - 1))
                                  : (hop_cnt == HW'(HOP_SIZE - 1));
    end
  end

  assign rd_en   = (state_q == ST_STREAM) && (!out_valid_q || out_ready_i) && !reset_i;
  assign last_rd = rd_en && (rd_cnt == IW'(FFT_SIZE - 1));

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    pend_d      = pend_q;
    pend_base_d = pend_base_q;
    overrun_d   = 1'b0;
    case (state_q)
      ST_FILL, ST_IDLE: begin
        if (trig) begin
          state_d = ST_STREAM;
          base_d  = trig_base;
        end
      end
      ST_STREAM: begin
        if (last_rd) begin
          // Frame ends: chain into the pending frame, or a coincident trigger, without a bubble.
          if (pend_q) begin
            base_d = pend_base_q;
            pend_d = trig;
            if (trig) pend_base_d = trig_base;
          end else if (trig) begin
            base_d = trig_base;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (trig) begin
          if (pend_q) begin
            overrun_d = 1'b1;
          end else begin
            pend_d      = 1'b1;
            pend_base_d = trig_base;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_comb begin
    wr_ptr_d    = sample_valid_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
    smp_cnt_d   = (sample_valid_i && (state_q == ST_FILL)) ? smp_cnt_q + IW'(1) : smp_cnt_q;
    out_valid_d = rd_en || (out_valid_q && !out_ready_i);
    out_idx_d   = rd_en ? rd_cnt : out_idx_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_FILL;
      wr_ptr_q    <= '0;
      smp_cnt_q   <= '0;
      base_q      <= '0;
      pend_q      <= 1'b0;
      pend_base_q <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      smp_cnt_q   <= smp_cnt_d;
      base_q      <= base_d;
      pend_q      <= pend_d;
      pend_base_q <= pend_base_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef STFT_SCHED_OVR_CNT_EN
  logic [OVR_CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (overrun_d && (ovr_cnt_q != '1)) ovr_cnt_d = ovr_cnt_q + 16'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ovr_cnt_q <= '0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign overrun_cnt_o = ovr_cnt_q;
`endif

  assign mem_we_o    = sample_valid_i;
  assign mem_waddr_o = wr_ptr_q;
  assign mem_wdata_o = sample_i;
  assign mem_re_o    = rd_en;
  assign mem_raddr_o = AW'(base_q + AW'(rd_cnt));
  assign out_valid_o = out_valid_q;
  assign out_data_o  = mem_rdata_i;
  assign out_idx_o   = out_idx_q;
  assign out_first_o = out_valid_q && (out_idx_q == '0);
  assign out_last_o  = out_valid_q && (out_idx_q == IW'(FFT_SIZE - 1));
  assign busy_o      = (state_q == ST_STREAM) || out_valid_q;
  assign overrun_o   = overrun_q;

endmodule
